// File: rtl/seq_mult_param_if.sv
// Handshake and data bus for seq_mult_param.
// Ports (slave view): iStart, iSigned, iData_A, iData_B in;
//                     oReady, oDone, oResult out.
interface seq_mult_param_if #(
  parameter int unsigned WIDTH = 16
);
  logic               iStart;
  logic               iSigned;
  logic [WIDTH-1:0]   iData_A;
  logic [WIDTH-1:0]   iData_B;
  logic               oReady;
  logic               oDone;
  logic [2*WIDTH-1:0] oResult;

  modport master (
    output iStart, iSigned, iData_A, iData_B,
    input  oReady, oDone, oResult
  );

  modport slave (
    input  iStart, iSigned, iData_A, iData_B,
    output oReady, oDone, oResult
  );
endinterface

// File: rtl/seq_mult_param.sv
// Iterative shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with
// per-operation signed/unsigned mode. One product every WIDTH+2 cycles.
// Ports: Clock, Reset (async active-low), bus (seq_mult_param_if.slave):
//   iStart/iSigned/iData_A/iData_B in, oReady/oDone/oResult out (registered).
module seq_mult_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  seq_mult_param_if.slave bus
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state,  stateNext;
  logic [WIDTH-1:0] magA,   magANext;
  logic [WIDTH-1:0] magB,   magBNext;
  logic             neg,    negNext;
  logic [ProdW-1:0] acc,    accNext;
  logic [CntW-1:0]  cnt,    cntNext;
  logic [ProdW-1:0] result, resultNext;
  logic             ready,  readyNext;
  logic             done,   doneNext;

  logic [ProdW-1:0] partial;
  logic [ProdW-1:0] accSum;
  logic             lastIter;

  // Current iteration's accumulator value; also the final product magnitude.
  assign partial  = ProdW'(magA) << cnt;
  assign accSum   = magB[cnt] ? (acc + partial) : acc;
  // Compare against WIDTH-1 so the counter never has to hold WIDTH.
  assign lastIter = (cnt == CntW'(WIDTH - 1));

  // Next-state and datapath update.
  always_comb begin
    stateNext  = state;
    magANext   = magA;
    magBNext   = magB;
    negNext    = neg;
    accNext    = acc;
    cntNext    = cnt;
    resultNext = result;

    case (state)
      StIdle: begin
        if (bus.iStart) begin
          // -(most-negative) wraps to 2^(WIDTH-1), which is the correct magnitude.
          magANext  = (bus.iSigned && bus.iData_A[WIDTH-1]) ? -bus.iData_A : bus.iData_A;
          magBNext  = (bus.iSigned && bus.iData_B[WIDTH-1]) ? -bus.iData_B : bus.iData_B;
          negNext   = bus.iSigned & (bus.iData_A[WIDTH-1] ^ bus.iData_B[WIDTH-1]);
          accNext   = '0;
          cntNext   = '0;
          stateNext = StBusy;
        end
      end
      StBusy: begin
        accNext = accSum;
        cntNext = cnt + CntW'(1);
        if (lastIter) begin
          resultNext = neg ? -accSum : accSum;
          stateNext  = StDone;
        end
      end
      StDone: begin
        stateNext = StIdle;
      end
      default: begin
        stateNext = StIdle;
      end
    endcase

    readyNext = (stateNext == StIdle);
    doneNext  = (stateNext == StDone);
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= StIdle;
      magA   <= '0;
      magB   <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= stateNext;
      magA   <= magANext;
      magB   <= magBNext;
      neg    <= negNext;
      acc    <= accNext;
      cnt    <= cntNext;
      result <= resultNext;
      ready  <= readyNext;
      done   <= doneNext;
    end
  end

  assign bus.oReady  = ready;
  assign bus.oDone   = done;
  assign bus.oResult = result;

endmodule
